// File: rtl/ahb_decoder_param.sv
// -----------------------------------------------------------------------------
// ahb_decoder_param
//
// AHB-Lite address decoder and response multiplexer for one master port of
// the SoC bus matrix.
//
// Address phase:
//   Each active transfer (NONSEQ/SEQ) is compared against NUM_SLV base/mask
//   regions. The combinational one-hot hsel selects the lowest-indexed
//   enabled region that matches.
//
// Data phase:
//   hsel/hwrite are registered into hsel_d/hwrite_d when a transfer is
//   accepted (hready_out=1). The selected slave's HREADYOUT/HRESP/HRDATA are
//   then routed back to the master.
//
// Default slave:
//   An active transfer that hits no region gets the two-cycle AHB ERROR
//   response (ERR1: not ready + ERROR, ERR2: ready + ERROR). The first
//   offending address since the last clear is captured in err_addr, and the
//   sticky err_flag is set.
//
// Ports:
//   hclk, hresetn  bus clock; synchronous active-low reset
//   haddr          address-phase address
//   htrans         transfer type
//   hwrite         address-phase write
//   hready_in      per-slave HREADYOUT
//   hresp_in       per-slave HRESP (1 = ERROR)
//   hrdata_in      per-slave read data; slice i belongs to slave i
//   hsel           combinational one-hot address-phase select
//   hsel_d         registered data-phase select
//   hwrite_d       registered data-phase write
//   hready_out     muxed HREADY to the master and to all slaves
//   hresp_out      muxed HRESP to the master
//   hrdata_out     muxed read data (zero when no slave owns the data phase)
//   err_flag       sticky: an unmapped active transfer was accepted
//   err_addr       address of the first unmapped access since the last clear
//   err_clr        clears err_flag and rearms err_addr capture
// -----------------------------------------------------------------------------
module ahb_decoder_param #(
  parameter int unsigned                 NUM_SLV  = 15,
  parameter int unsigned                 ADDR_W   = 32,
  parameter int unsigned                 DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = '0,
  parameter logic [NUM_SLV-1:0]          SLV_EN   = '1
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic [ADDR_W-1:0]              haddr,
  input  logic [1:0]                     htrans,
  input  logic                           hwrite,
  input  logic [NUM_SLV-1:0]             hready_in,
  input  logic [NUM_SLV-1:0]             hresp_in,
  input  logic [NUM_SLV*DATA_W-1:0]      hrdata_in,
  output logic [NUM_SLV-1:0]             hsel,
  output logic [NUM_SLV-1:0]             hsel_d,
  output logic                           hwrite_d,
  output logic                           hready_out,
  output logic                           hresp_out,
  output logic [DATA_W-1:0]              hrdata_out,
  output logic                           err_flag,
  output logic [ADDR_W-1:0]              err_addr,
  input  logic                           err_clr
);

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [NUM_SLV-1:0] hit_vec;
  logic [NUM_SLV-1:0] hit_lowest;
  logic               xfer_active;
  logic               unmapped;

  always_comb begin
    // NOTE: every signal driven from always_comb gets a default before any
    // conditional logic, so no path leaves it unassigned and no latch results.
    hit_vec = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      hit_vec[i] = SLV_EN[i] &&
                   ((haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
    end
  end

  // Two's-complement trick: x & -x isolates the lowest set bit, which gives
  // lowest-index priority when regions overlap and keeps hsel one-hot.
  assign hit_lowest  = hit_vec & (~hit_vec + NUM_SLV'(1));

  assign xfer_active = (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
  assign unmapped    = xfer_active && (hit_vec == '0);
  assign hsel        = xfer_active ? hit_lowest : '0;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  err_state_e          state_q,    state_d;
  logic [NUM_SLV-1:0]  hsel_d_q,   hsel_d_d;
  logic                hwrite_d_q, hwrite_d_d;
  logic                err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  // An unmapped active transfer is being accepted this cycle. This is the
  // only way into ERR1, so it also serves as the error-capture strobe.
  logic err_entry;

  // ---------------------------------------------------------------------------
  // Response multiplexer
  // ---------------------------------------------------------------------------
  always_comb begin
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    hrdata_out = '0;

    // hsel_d_q is one-hot or zero, so an OR of gated slices is a clean mux
    // that naturally returns zero when no slave owns the data phase.
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      hrdata_out = hrdata_out | (hrdata_in[i*DATA_W +: DATA_W] & {DATA_W{hsel_d_q[i]}});
      if (hsel_d_q[i]) begin
        hready_out = hready_in[i];
        hresp_out  = hresp_in[i];
      end
    end

    // The default slave owns the data phase while in ERR1/ERR2; hsel_d_q is
    // zero there because the unmapped transfer loaded an all-zero select.
    unique case (state_q)
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = 1'b1;
      end
      ST_ERR2: begin
        hready_out = 1'b1;
        hresp_out  = 1'b1;
      end
      default: ;
    endcase
  end

  assign err_entry = hready_out && unmapped;

  // ---------------------------------------------------------------------------
  // Default-slave FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (err_entry) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      // hready_out is high in ERR2, so a new unmapped transfer is accepted
      // here and chains straight into another error response.
      ST_ERR2: state_d = err_entry ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data-phase pipeline and error capture next state
  // ---------------------------------------------------------------------------
  always_comb begin
    hsel_d_d   = hsel_d_q;
    hwrite_d_d = hwrite_d_q;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;

    // The address phase only advances when the current data phase completes.
    if (hready_out) begin
      hsel_d_d   = hsel;
      hwrite_d_d = hwrite;
    end

    if (err_clr) begin
      err_flag_d = 1'b0;
    end

    // A capture outranks a simultaneous clear. The clear also rearms the
    // address register, so a coincident capture loads the new address.
    if (err_entry) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || err_clr) begin
        err_addr_d = haddr;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      hsel_d_q   <= '0;
      hwrite_d_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      hsel_d_q   <= hsel_d_d;
      hwrite_d_q <= hwrite_d_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign hsel_d   = hsel_d_q;
  assign hwrite_d = hwrite_d_q;
  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ahb_decoder_param.sv
// -----------------------------------------------------------------------------
// tb_ahb_decoder_param
//
// Directed testbench for ahb_decoder_param. Region map used by the main
// instance (all masks applied to a 32-bit address):
//   slave 1 : base 0x1000_0000 mask 0xF000_0000
//   slave 2 : base 0x2000_0000 mask 0xF000_0000
//   slave 3 : base 0x3000_0000 mask 0xF000_0000
//   slave 4 : base 0x4000_0000 mask 0xF000_0000
//   slave 5 : base 0x2000_0000 mask 0xFF00_0000 (overlaps slave 2)
//   others  : disabled
// A second instance has slave 2 disabled as well, for the overlap check.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 time unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_ahb_decoder_param;

  localparam int unsigned NUM_SLV = 15;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;

  localparam logic [NUM_SLV*ADDR_W-1:0] BASE =
    {{9{32'h0}}, 32'h2000_0000, 32'h4000_0000, 32'h3000_0000,
     32'h2000_0000, 32'h1000_0000, 32'h0};
  localparam logic [NUM_SLV*ADDR_W-1:0] MASK =
    {{9{32'h0}}, 32'hFF00_0000, {4{32'hF000_0000}}, 32'h0};
  localparam logic [NUM_SLV-1:0] EN_A = 15'h003E;
  localparam logic [NUM_SLV-1:0] EN_B = 15'h003A;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic                      hclk;
  logic                      hresetn;
  logic [ADDR_W-1:0]         haddr;
  logic [1:0]                htrans;
  logic                      hwrite;
  logic [NUM_SLV-1:0]        hready_in;
  logic [NUM_SLV-1:0]        hresp_in;
  logic [NUM_SLV*DATA_W-1:0] hrdata_in;
  logic                      err_clr;

  logic [NUM_SLV-1:0]        hsel, hsel_d;
  logic                      hwrite_d, hready_out, hresp_out, err_flag;
  logic [DATA_W-1:0]         hrdata_out;
  logic [ADDR_W-1:0]         err_addr;

  logic [NUM_SLV-1:0]        b_hsel, b_hsel_d;
  logic                      b_hwrite_d, b_hready_out, b_hresp_out, b_err_flag;
  logic [DATA_W-1:0]         b_hrdata_out;
  logic [ADDR_W-1:0]         b_err_addr;

  int n_checks = 0;
  int n_errors = 0;

  ahb_decoder_param #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .SLV_EN(EN_A)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready_in(hready_in), .hresp_in(hresp_in),
    .hrdata_in(hrdata_in), .hsel(hsel), .hsel_d(hsel_d), .hwrite_d(hwrite_d),
    .hready_out(hready_out), .hresp_out(hresp_out), .hrdata_out(hrdata_out),
    .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  ahb_decoder_param #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .SLV_EN(EN_B)
  ) dut_b (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready_in(hready_in), .hresp_in(hresp_in),
    .hrdata_in(hrdata_in), .hsel(b_hsel), .hsel_d(b_hsel_d),
    .hwrite_d(b_hwrite_d), .hready_out(b_hready_out), .hresp_out(b_hresp_out),
    .hrdata_out(b_hrdata_out), .err_flag(b_err_flag), .err_addr(b_err_addr),
    .err_clr(err_clr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
    haddr  = a;
    htrans = t;
    hwrite = w;
  endtask

  // Global time limit: the stimulus is a fixed number of cycles, this only
  // guards against a stalled simulation.
  initial begin
    #20000;
    $display("FAIL timeout got=0x0 exp=0x1");
    $fatal(1, "time limit reached");
  end

  initial begin
    hresetn   = 1'b0;
    err_clr   = 1'b0;
    hready_in = '1;
    hresp_in  = '0;
    hrdata_in = '0;
    hrdata_in[1*DATA_W +: DATA_W] = 32'h1111_0001;
    hrdata_in[4*DATA_W +: DATA_W] = 32'h4444_0004;
    drive(32'h0, T_IDLE, 1'b0);

    // ---------------- reset state ----------------
    tick(); tick();
    hresetn = 1'b1;
    #1;
    check("rst_hsel",     hsel,       0);
    check("rst_hsel_d",   hsel_d,     0);
    check("rst_hwrite_d", hwrite_d,   0);
    check("rst_hready",   hready_out, 1);
    check("rst_hresp",    hresp_out,  0);
    check("rst_hrdata",   hrdata_out, 0);
    check("rst_err_flag", err_flag,   0);
    check("rst_err_addr", err_addr,   0);

    // ---------------- mapped read with two wait states ----------------
    drive(32'h3000_0010, T_NONSEQ, 1'b0);
    #1;
    check("rd_hsel",  hsel,       15'h0008);
    check("rd_ready", hready_out, 1);
    tick();
    // data phase, wait 1; master already presents a write to slave 1
    hready_in[3] = 1'b0;
    drive(32'h1000_0000, T_NONSEQ, 1'b1);
    #1;
    check("rd_hsel_d",  hsel_d,     15'h0008);
    check("rd_wait1",   hready_out, 0);
    check("wr_hsel_pend", hsel,     15'h0002);
    tick();
    #1;
    check("rd_hold_hsel_d",   hsel_d,     15'h0008);
    check("rd_hold_hwrite_d", hwrite_d,   0);
    check("rd_wait2",         hready_out, 0);
    tick();
    hready_in[3] = 1'b1;
    hrdata_in[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    #1;
    check("rd_ready_end", hready_out, 1);
    check("rd_hresp",     hresp_out,  0);
    check("rd_data",      hrdata_out, 32'hDEAD_BEEF);
    tick();
    drive(32'h0, T_IDLE, 1'b0);
    #1;
    check("wr_hsel_d",   hsel_d,     15'h0002);
    check("wr_hwrite_d", hwrite_d,   1);
    check("wr_ready",    hready_out, 1);
    tick();
    #1;
    check("idle_hsel_d", hsel_d,     0);
    check("idle_hrdata", hrdata_out, 0);

    // ---------------- IDLE/BUSY to unmapped address ----------------
    drive(32'hF000_0000, T_IDLE, 1'b0);
    #1;
    check("idle_um_hsel", hsel, 0);
    tick();
    drive(32'hF000_0000, T_BUSY, 1'b0);
    #1;
    check("busy_um_hsel",  hsel,       0);
    check("idle_um_ready", hready_out, 1);
    tick();
    drive(32'h0, T_IDLE, 1'b0);
    #1;
    check("busy_um_ready", hready_out, 1);
    check("busy_um_hresp", hresp_out,  0);
    check("busy_um_flag",  err_flag,   0);

    // ---------------- overlap priority / disabled slave ----------------
    drive(32'h2000_0000, T_NONSEQ, 1'b0);
    #1;
    check("ovl_hsel",    hsel,   15'h0004);
    check("ovl_en_hsel", b_hsel, 15'h0020);
    drive(32'h2100_0000, T_NONSEQ, 1'b0);
    #1;
    check("ovl2_hsel",    hsel,   15'h0004);
    check("ovl2_en_hsel", b_hsel, 15'h0000);
    drive(32'h0, T_IDLE, 1'b0);
    tick();

    // ---------------- unmapped NONSEQ, error response ----------------
    drive(32'hF000_0004, T_NONSEQ, 1'b0);
    #1;
    check("um_hsel", hsel, 0);
    tick();
    // ERR1; master switches to a mapped transfer that must not be taken yet
    drive(32'h1000_0000, T_NONSEQ, 1'b1);
    #1;
    check("err1_ready",    hready_out, 0);
    check("err1_hresp",    hresp_out,  1);
    check("err1_flag",     err_flag,   1);
    check("err1_addr",     err_addr,   32'hF000_0004);
    tick();
    drive(32'h0, T_IDLE, 1'b0);
    #1;
    check("err2_ready",  hready_out, 1);
    check("err2_hresp",  hresp_out,  1);
    check("err2_hsel_d", hsel_d,     0);
    tick();
    #1;
    check("post_err_ready",  hready_out, 1);
    check("post_err_hresp",  hresp_out,  0);
    check("post_err_hsel_d", hsel_d,     0);

    // second unmapped access does not overwrite the captured address
    drive(32'hE000_0000, T_NONSEQ, 1'b0);
    tick();
    drive(32'h0, T_IDLE, 1'b0);
    #1;
    check("um2_err1_ready", hready_out, 0);
    check("um2_addr_kept",  err_addr,   32'hF000_0004);
    tick(); tick();

    // clear alone, then a new capture
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("clr_flag", err_flag, 0);
    drive(32'hE000_0100, T_NONSEQ, 1'b0);
    tick();
    drive(32'h0, T_IDLE, 1'b0);
    #1;
    check("recap_flag", err_flag, 1);
    check("recap_addr", err_addr, 32'hE000_0100);
    tick(); tick();

    // clear coinciding with a capture: the capture wins
    err_clr = 1'b1;
    drive(32'hD000_0000, T_NONSEQ, 1'b0);
    tick();
    err_clr = 1'b0;
    drive(32'h0, T_IDLE, 1'b0);
    #1;
    check("coinc_flag", err_flag, 1);
    check("coinc_addr", err_addr, 32'hD000_0000);
    tick(); tick();

    // ---------------- reset during a slave wait state ----------------
    drive(32'h3000_0020, T_NONSEQ, 1'b0);
    tick();
    drive(32'h0, T_IDLE, 1'b0);
    hready_in[3] = 1'b0;
    #1;
    check("wrst_waiting", hready_out, 0);
    hresetn = 1'b0;
    tick(); tick();
    hresetn = 1'b1;
    #1;
    check("wrst_hsel_d",   hsel_d,     0);
    check("wrst_ready",    hready_out, 1);
    check("wrst_hresp",    hresp_out,  0);
    check("wrst_err_flag", err_flag,   0);
    check("wrst_err_addr", err_addr,   0);
    hready_in[3] = 1'b1;

    // ---------------- pipelined: slave1 write, unmapped, slave4 read -----
    drive(32'h1000_0040, T_NONSEQ, 1'b1);
    tick();
    drive(32'hF000_0008, T_NONSEQ, 1'b0);
    #1;
    check("pl_wr_hsel_d",   hsel_d,     15'h0002);
    check("pl_wr_hwrite_d", hwrite_d,   1);
    check("pl_wr_ready",    hready_out, 1);
    check("pl_wr_hresp",    hresp_out,  0);
    tick();
    drive(32'h4000_0000, T_NONSEQ, 1'b0);
    #1;
    check("pl_err1_ready",    hready_out, 0);
    check("pl_err1_hresp",    hresp_out,  1);
    check("pl_err1_hsel_d",   hsel_d,     0);
    check("pl_err1_hwrite_d", hwrite_d,   0);
    check("pl_err1_addr",     err_addr,   32'hF000_0008);
    tick();
    #1;
    check("pl_err2_ready", hready_out, 1);
    check("pl_err2_hresp", hresp_out,  1);
    check("pl_rd_hsel",    hsel,       15'h0010);
    tick();
    drive(32'h0, T_IDLE, 1'b0);
    #1;
    check("pl_rd_hsel_d",   hsel_d,     15'h0010);
    check("pl_rd_hwrite_d", hwrite_d,   0);
    check("pl_rd_ready",    hready_out, 1);
    check("pl_rd_hresp",    hresp_out,  0);
    check("pl_rd_data",     hrdata_out, 32'h4444_0004);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
